pe256_drain_scheduler: RTL and testbench

- Sequential consumer of the 256-bit priority encoder (pe256_scalable).
- Captures a 256-bit request vector and serves every set bit, one per handshake, highest index first.
- The encoded index is fed back to clear the served bit, so each request is issued exactly once.
- Sits directly downstream of pe256_scalable. Drives a single-index valid/ready consumer such as a grant or service port.

---
 rtl/pe256_drain_scheduler_if.sv | 24 ++
 rtl/pe256_drain_scheduler.sv | 109 ++++++++++
 tb/tb_pe256_drain_scheduler.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pe256_drain_scheduler_if.sv
// Load and service handshakes of the pe256 drain scheduler.
// The slave side is the scheduler; the master side feeds vectors and consumes indices.
interface pe256_drain_scheduler_if #(
  parameter int WIDTH = 256,
  parameter int IDX_W = 8
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_vec;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;

  modport master (
    output load_valid, load_vec, out_ready,
    input  load_ready, out_valid, out_idx, out_last
  );

  modport slave (
    input  load_valid, load_vec, out_ready,
    output load_ready, out_valid, out_idx, out_last
  );
endinterface

// File: rtl/pe256_drain_scheduler.sv
// Serves every set bit of a captured request vector, highest index first,
// feeding the encoded index back to clear the bit that was just issued.
module pe256_scalable #(
  parameter int WIDTH = 256,
  parameter int IDX_W = 8
) (
  input  logic [WIDTH-1:0] d,
  output logic [IDX_W-1:0] q,
  output logic             v
);
  // Later iterations overwrite earlier ones, so the highest set bit wins.
  always_comb begin
    q = '0;
    v = |d;
    for (int i = 0; i < WIDTH; i++) begin
      if (d[i]) q = IDX_W'(i);
    end
  end
endmodule

module pe256_drain_scheduler #(
  parameter int WIDTH = 256,
  parameter int IDX_W = 8,
  parameter int CNT_W = 9
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  pe256_drain_scheduler_if.slave   bus,
  output logic                     busy,
  output logic                     done,
  output logic [CNT_W-1:0]         served_cnt
);
  typedef enum logic [0:0] {IDLE, DRAIN} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] pending_clr;
  logic [WIDTH-1:0] served_mask;
  logic [IDX_W-1:0] enc_q;
  logic             enc_v;
  logic             load_fire;
  logic             hs;

  pe256_scalable #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_enc (
    .d (pending),
    .q (enc_q),
    .v (enc_v)
  );

  assign served_mask  = {{(WIDTH-1){1'b0}}, 1'b1} << enc_q;
  assign pending_clr  = pending & ~served_mask;
  assign bus.out_idx  = enc_q;
  // Exactly one bit set: clearing the top one leaves nothing behind.
  assign bus.out_last = (state == DRAIN) & enc_v & ~(|pending_clr);
  assign load_fire    = bus.load_valid & bus.load_ready;
  assign hs           = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (load_fire && (|bus.load_vec)) state_nxt = DRAIN;
        DRAIN:   if (hs && bus.out_last)           state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.load_ready = (state == IDLE);
    bus.out_valid  = (state == DRAIN);
    busy           = (state == DRAIN);
  end

  // A handshake coinciding with flush still counts the index it accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= '0;
      served_cnt <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        pending <= '0;
        if (hs) served_cnt <= served_cnt + CNT_W'(1);
      end else if (load_fire) begin
        pending    <= bus.load_vec;
        served_cnt <= '0;
        done       <= ~(|bus.load_vec);
      end else if (hs) begin
        pending    <= pending_clr;
        served_cnt <= served_cnt + CNT_W'(1);
        done       <= bus.out_last;
      end
    end
  end
endmodule

// File: tb/tb_pe256_drain_scheduler.sv
// Randomized bench for pe256_drain_scheduler; expected index streams come from
// a descending scan of each loaded vector.
module tb_pe256_drain_scheduler;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       busy;
  logic       done;
  logic [8:0] served_cnt;
  int         vectors = 0;
  int         miscompares = 0;

  pe256_drain_scheduler_if bus ();

  pe256_drain_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .served_cnt (served_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] rand_vec(input int density);
    logic [255:0] v;
    logic [31:0]  w;
    for (int k = 0; k < 8; k++) begin
      w = $urandom;
      if (density >= 1) w &= $urandom;
      if (density >= 2) w &= $urandom & $urandom;
      v[k*32 +: 32] = w;
    end
    return v;
  endfunction

  task automatic load(input logic [255:0] v);
    bus.load_vec   = v;
    bus.load_valid = 1'b1;
    @(negedge clk);
    bus.load_valid = 1'b0;
  endtask

  // Called in the cycle after a vector was accepted; follows it to completion.
  task automatic drain(input logic [255:0] v, input int stall, input bit rnd, input string name);
    int q[$];
    int n;
    int cyc;
    int budget;
    for (int i = 255; i >= 0; i--) if (v[i]) q.push_back(i);
    n = q.size();
    cyc = 0;
    budget = 4 * n + stall + 50;
    while (q.size() > 0 && cyc < budget) begin
      bus.out_ready = (cyc < stall) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      if (rnd) begin
        bus.load_valid = 1'($urandom_range(0, 1));
        bus.load_vec   = rand_vec(0);
      end
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.load_ready !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
        miscompares++;
        $display("FAIL %s ctrl cyc=%0d: valid=%b ready=%b busy=%b done=%b, want 1 0 1 0",
                 name, cyc, bus.out_valid, bus.load_ready, busy, done);
      end
      vectors++;
      if (bus.out_idx !== 8'(q[0])) begin
        miscompares++;
        $display("FAIL %s idx cyc=%0d: got %0d, want %0d", name, cyc, bus.out_idx, q[0]);
      end
      vectors++;
      if (bus.out_last !== (q.size() == 1)) begin
        miscompares++;
        $display("FAIL %s last cyc=%0d: got %b, want %b", name, cyc, bus.out_last, q.size() == 1);
      end
      if (bus.out_ready) void'(q.pop_front());
      @(negedge clk);
      cyc++;
    end
    bus.load_valid = 1'b0;
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL %s timeout: %0d indices left, want 0", name, q.size());
    end
    vectors++;
    if (done !== 1'b1 || bus.out_valid !== 1'b0 || bus.load_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s finish: done=%b valid=%b ready=%b busy=%b, want 1 0 1 0",
               name, done, bus.out_valid, bus.load_ready, busy);
    end
    vectors++;
    if (served_cnt !== 9'(n)) begin
      miscompares++;
      $display("FAIL %s served_cnt: got %0d, want %0d", name, served_cnt, n);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL %s done width: got %b, want 0", name, done);
    end
  endtask

  task automatic test_reset();
    bus.load_valid = 1'b0;
    bus.load_vec   = '0;
    bus.out_ready  = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.out_idx !== 8'd0 || bus.out_last !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0 || served_cnt !== 9'd0) begin
      miscompares++;
      $display("FAIL reset_values: valid=%b idx=%0d last=%b busy=%b done=%b cnt=%0d, want all 0",
               bus.out_valid, bus.out_idx, bus.out_last, busy, done, served_cnt);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.load_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready: ready=%b valid=%b, want 1 0", bus.load_ready, bus.out_valid);
    end
  endtask

  task automatic test_basic();
    logic [255:0] v = '0;
    v[200] = 1'b1; v[123] = 1'b1; v[5] = 1'b1;
    load(v);
    drain(v, 0, 1'b0, "basic");
  endtask

  task automatic test_zero();
    logic [255:0] v = '0;
    load(v);
    drain(v, 0, 1'b0, "zero");
  endtask

  task automatic test_stall();
    logic [255:0] v = '0;
    v[255] = 1'b1; v[0] = 1'b1;
    bus.out_ready = 1'b0;
    load(v);
    drain(v, 4, 1'b0, "stall");
  endtask

  task automatic test_all_ones();
    logic [255:0] v = '1;
    load(v);
    drain(v, 0, 1'b0, "all_ones");
  endtask

  task automatic test_flush();
    logic [255:0] v = '0;
    v[10] = 1'b1; v[20] = 1'b1; v[30] = 1'b1;
    bus.out_ready = 1'b1;
    load(v);
    vectors++;
    if (bus.out_idx !== 8'd30 || bus.out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_first: idx=%0d valid=%b, want 30 1", bus.out_idx, bus.out_valid);
    end
    @(negedge clk);
    vectors++;
    if (bus.out_idx !== 8'd20 || served_cnt !== 9'd1) begin
      miscompares++;
      $display("FAIL flush_second: idx=%0d cnt=%0d, want 20 1", bus.out_idx, served_cnt);
    end
    flush = 1'b1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || served_cnt !== 9'd1 ||
        bus.load_ready !== 1'b1 || bus.out_idx !== 8'd0) begin
      miscompares++;
      $display("FAIL flush_abort: valid=%b busy=%b done=%b cnt=%0d ready=%b idx=%0d, want 0 0 0 1 1 0",
               bus.out_valid, busy, done, served_cnt, bus.load_ready, bus.out_idx);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_no_done: got %b, want 0", done);
    end
    v = '0; v[7] = 1'b1;
    bus.out_ready = 1'b1;
    load(v);
    drain(v, 0, 1'b0, "flush_reload");
    // Handshake and flush in the same cycle.
    v = '0; v[50] = 1'b1; v[40] = 1'b1;
    load(v);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b0 || served_cnt !== 9'd1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_with_hs: valid=%b cnt=%0d done=%b, want 0 1 0", bus.out_valid, served_cnt, done);
    end
    // Load in the same cycle as flush is ignored.
    v = '0; v[99] = 1'b1;
    bus.load_vec = v;
    bus.load_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    bus.load_valid = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b0 || served_cnt !== 9'd1 || bus.load_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_with_load: valid=%b cnt=%0d ready=%b, want 0 1 1", bus.out_valid, served_cnt, bus.load_ready);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_with_load_after: done=%b valid=%b, want 0 0", done, bus.out_valid);
    end
  endtask

  task automatic test_random();
    logic [255:0] v;
    for (int t = 0; t < 20; t++) begin
      v = rand_vec($urandom_range(0, 2));
      if (t == 5) v = '0;
      if (t == 6) begin v = '0; v[0] = 1'b1; end
      load(v);
      drain(v, $urandom_range(0, 3), 1'b1, "random");
    end
  endtask

  task automatic test_reset_mid_drain();
    logic [255:0] v;
    v = rand_vec(1);
    v[255] = 1'b1; v[3] = 1'b1;
    bus.out_ready = 1'b1;
    load(v);
    @(negedge clk);
    bus.out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.out_idx !== 8'd0 || bus.out_last !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0 || served_cnt !== 9'd0) begin
      miscompares++;
      $display("FAIL async_reset: valid=%b idx=%0d last=%b busy=%b done=%b cnt=%0d, want all 0",
               bus.out_valid, bus.out_idx, bus.out_last, busy, done, served_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.load_ready !== 1'b1 || bus.out_valid !== 1'b0 || served_cnt !== 9'd0) begin
      miscompares++;
      $display("FAIL reset_no_resume: ready=%b valid=%b cnt=%0d, want 1 0 0",
               bus.load_ready, bus.out_valid, served_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_stall();
    test_all_ones();
    test_flush();
    test_random();
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
